// File: rtl/alu_sequencer.sv
// alu_sequencer
// Multi-cycle controller for the RISC-16 datapath. Accepts one register-register
// instruction over a valid/ready handshake, owns a 16 x 16-bit register file and
// steps an external combinational ALU through READ -> EXEC -> WB, latching the
// written-back result and the ALU carry/zero/parity flags.
//
// Ports:
//   clk, rst                    rising-edge clock, synchronous active-high reset
//   instr_valid/instr_ready     instruction handshake (ready only in IDLE)
//   instr[15:0]                 {op, rx, ry, rd}
//   load_en/load_addr/load_data host register write, honoured only while ready
//   alu_rx_value/alu_ry_value   registered ALU operands
//   alu_opcode                  registered ALU opcode
//   alu_out, alu_carry,
//   alu_zero, alu_parity        ALU result and flags
//   done                        one-cycle retire pulse
//   result, flags               last written-back value, {carry, zero, parity}
//   halted                      high once a HALT instruction has been accepted
//   dbg_addr/dbg_data           combinational register-file read port

module alu_sequencer #(
    parameter logic [3:0] NOP_OPCODE  = 4'h0,
    parameter logic [3:0] HALT_OPCODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] instr,
    input  logic        load_en,
    input  logic [3:0]  load_addr,
    input  logic [15:0] load_data,
    output logic [15:0] alu_rx_value,
    output logic [15:0] alu_ry_value,
    output logic [3:0]  alu_opcode,
    input  logic [15:0] alu_out,
    input  logic        alu_carry,
    input  logic        alu_zero,
    input  logic        alu_parity,
    output logic        done,
    output logic [15:0] result,
    output logic [2:0]  flags,
    output logic        halted,
    input  logic [3:0]  dbg_addr,
    output logic [15:0] dbg_data
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_EXEC = 3'd2,
        S_WB   = 3'd3,
        S_HALT = 3'd4
    } state_t;

    state_t       state_q;
    state_t       state_d;
    logic [15:0]  ir_q;
    logic [15:0]  ir_d;
    logic [15:0]  regs_q [16];
    logic [15:0]  rx_value_q;
    logic [15:0]  ry_value_q;
    logic [3:0]   opcode_q;
    logic [15:0]  result_q;
    logic [2:0]   flags_q;

    logic         rf_we_s;
    logic [3:0]   rf_waddr_s;
    logic [15:0]  rf_wdata_s;
    logic [3:0]   new_op_s;

    assign new_op_s = instr[15:12];

    // Next-state logic and instruction-register capture.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    ir_d = instr;
                    if (new_op_s == HALT_OPCODE) begin
                        state_d = S_HALT;
                    end else if (new_op_s == NOP_OPCODE) begin
                        // NOP skips the ALU entirely but still retires through WB.
                        state_d = S_WB;
                    end else begin
                        state_d = S_READ;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ:  state_d = S_EXEC;
            S_EXEC:  state_d = S_WB;
            S_WB:    state_d = S_IDLE;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // Register-file write port: host load in IDLE, ALU write-back in EXEC.
    // The two sources live in different states, so they never collide.
    always_comb begin
        rf_we_s    = 1'b0;
        rf_waddr_s = 4'h0;
        rf_wdata_s = 16'h0000;
        if ((state_q == S_IDLE) && load_en) begin
            rf_we_s    = 1'b1;
            rf_waddr_s = load_addr;
            rf_wdata_s = load_data;
        end else if (state_q == S_EXEC) begin
            rf_we_s    = 1'b1;
            rf_waddr_s = ir_q[3:0];
            rf_wdata_s = alu_out;
        end else begin
            rf_we_s    = 1'b0;
        end
    end

    // State and instruction register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // Register file; a reset mid-instruction drops the pending write-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= 16'h0000;
            end
        end else if (rf_we_s) begin
            regs_q[rf_waddr_s] <= rf_wdata_s;
        end
    end

    // ALU operand/opcode registers (held between instructions) and result/flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_value_q <= 16'h0000;
            ry_value_q <= 16'h0000;
            opcode_q   <= 4'h0;
            result_q   <= 16'h0000;
            flags_q    <= 3'b000;
        end else begin
            if (state_q == S_READ) begin
                rx_value_q <= regs_q[ir_q[11:8]];
                ry_value_q <= regs_q[ir_q[7:4]];
                opcode_q   <= ir_q[15:12];
            end
            if (state_q == S_EXEC) begin
                result_q <= alu_out;
                flags_q  <= {alu_carry, alu_zero, alu_parity};
            end
        end
    end

    assign instr_ready  = (state_q == S_IDLE);
    assign done         = (state_q == S_WB);
    assign halted       = (state_q == S_HALT);
    assign alu_rx_value = rx_value_q;
    assign alu_ry_value = ry_value_q;
    assign alu_opcode   = opcode_q;
    assign result       = result_q;
    assign flags        = flags_q;
    assign dbg_data     = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: a small behavioural ALU closes the loop, a
// register-file model predicts each retire and pushes {flags, result} to a
// scoreboard queue that a monitor pops whenever done pulses.

module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic        load_en;
    logic [3:0]  load_addr;
    logic [15:0] load_data;
    logic [15:0] alu_rx_value;
    logic [15:0] alu_ry_value;
    logic [3:0]  alu_opcode;
    logic [15:0] alu_out;
    logic        alu_carry;
    logic        alu_zero;
    logic        alu_parity;
    logic        done;
    logic [15:0] result;
    logic [2:0]  flags;
    logic        halted;
    logic [3:0]  dbg_addr;
    logic [15:0] dbg_data;

    int n_checks = 0;
    int n_pass   = 0;

    logic [18:0] sb_q[$];
    logic [15:0] m_regs [16];
    logic [15:0] m_result;
    logic [2:0]  m_flags;

    alu_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr        (instr),
        .load_en      (load_en),
        .load_addr    (load_addr),
        .load_data    (load_data),
        .alu_rx_value (alu_rx_value),
        .alu_ry_value (alu_ry_value),
        .alu_opcode   (alu_opcode),
        .alu_out      (alu_out),
        .alu_carry    (alu_carry),
        .alu_zero     (alu_zero),
        .alu_parity   (alu_parity),
        .done         (done),
        .result       (result),
        .flags        (flags),
        .halted       (halted),
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // Behavioural ALU: returns {carry, zero, parity, out}; parity is 1 for an even count of ones.
    function automatic logic [18:0] alu_f(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] wide;
        logic [31:0] prod;
        logic [15:0] o;
        logic        c;
        wide = 17'h0;
        prod = 32'h0;
        c    = 1'b0;
        case (op)
            4'h1: begin wide = {1'b0, a} + {1'b0, b}; o = wide[15:0]; c = wide[16]; end
            4'h2: begin wide = {1'b0, a} - {1'b0, b}; o = wide[15:0]; c = wide[16]; end
            4'h3: begin prod = a * b; o = prod[15:0]; c = |prod[31:16]; end
            4'h4: o = a & b;
            4'h5: o = a | b;
            4'h6: o = a ^ b;
            default: o = a;
        endcase
        return {c, (o == 16'h0000), ~(^o), o};
    endfunction

    // Bench ALU driven from the DUT's registered operands.
    always_comb begin
        {alu_carry, alu_zero, alu_parity, alu_out} = alu_f(alu_opcode, alu_rx_value, alu_ry_value);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest prediction.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                check_eq("spurious_done", 32'(done), 32'd0);
            end else begin
                logic [18:0] e;
                e = sb_q.pop_front();
                check_eq("sb_result", 32'(result), 32'(e[15:0]));
                check_eq("sb_flags", 32'(flags), 32'(e[18:16]));
            end
        end
    end

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_regs[i] = 16'h0000;
        m_result = 16'h0000;
        m_flags  = 3'b000;
    endtask

    task automatic check_reg(input string tag, input logic [3:0] a, input logic [15:0] e);
        dbg_addr = a;
        #1;
        check_eq(tag, 32'(dbg_data), 32'(e));
    endtask

    task automatic host_load(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        load_en = 1'b1; load_addr = a; load_data = d;
        @(negedge clk);
        load_en = 1'b0;
        m_regs[a] = d;
    endtask

    // Predict an instruction into the model and scoreboard.
    task automatic predict(input logic [15:0] ins);
        logic [18:0] r;
        if (ins[15:12] == 4'h0) begin
            sb_q.push_back({m_flags, m_result});
        end else begin
            r = alu_f(ins[15:12], m_regs[ins[11:8]], m_regs[ins[7:4]]);
            m_regs[ins[3:0]] = r[15:0];
            m_result = r[15:0];
            m_flags  = r[18:16];
            sb_q.push_back(r);
        end
    endtask

    // Issue one instruction (optionally with a same-cycle host load) and check retire latency.
    task automatic run_instr(input logic [15:0] ins, input logic ld, input logic [3:0] la, input logic [15:0] ldd);
        int cnt;
        int exp_lat;
        logic [15:0] a;
        logic [15:0] b;
        @(negedge clk);
        instr_valid = 1'b1;
        instr = ins;
        cnt = 0;
        while (!instr_ready && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 20) check_eq("accept_timeout", 32'(instr_ready), 32'd1);
        load_en = ld; load_addr = la; load_data = ldd;
        if (ld) m_regs[la] = ldd;
        a = m_regs[ins[11:8]];
        b = m_regs[ins[7:4]];
        exp_lat = (ins[15:12] == 4'h0) ? 1 : 3;
        predict(ins);
        @(negedge clk);
        instr_valid = 1'b0;
        load_en = 1'b0;
        cnt = 1;
        while (!done && cnt < 10) begin
            if (cnt == 2) begin
                check_eq("exec_opcode", 32'(alu_opcode), 32'(ins[15:12]));
                check_eq("exec_rx", 32'(alu_rx_value), 32'(a));
                check_eq("exec_ry", 32'(alu_ry_value), 32'(b));
            end
            @(negedge clk);
            cnt++;
        end
        check_eq("done_latency", 32'(cnt), 32'(exp_lat));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        rst = 1'b1; instr_valid = 1'b0; instr = 16'h0000;
        load_en = 1'b0; load_addr = 4'h0; load_data = 16'h0000; dbg_addr = 4'h0;
        model_clear();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state.
        check_eq("rst_ready", 32'(instr_ready), 32'd1);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_halted", 32'(halted), 32'd0);
        check_eq("rst_result", 32'(result), 32'd0);
        check_eq("rst_flags", 32'(flags), 32'd0);
        check_eq("rst_alu_op", 32'(alu_opcode), 32'd0);
        check_reg("rst_r5", 4'h5, 16'h0000);

        host_load(4'h1, 16'h0005);
        host_load(4'h2, 16'h0003);

        run_instr(16'h1123, 1'b0, 4'h0, 16'h0000);
        check_reg("add_r3", 4'h3, 16'h0008);
        check_eq("add_result", 32'(result), 32'h0008);
        check_eq("add_zero", 32'(flags[1]), 32'd0);

        run_instr(16'h3124, 1'b0, 4'h0, 16'h0000);
        check_reg("mul_r4", 4'h4, 16'h000F);
        check_eq("mul_parity", 32'(flags[0]), 32'd1);

        run_instr(16'h2115, 1'b0, 4'h0, 16'h0000);
        check_reg("sub0_r5", 4'h5, 16'h0000);
        check_eq("sub0_zero", 32'(flags[1]), 32'd1);
        run_instr(16'h2125, 1'b0, 4'h0, 16'h0000);
        check_reg("sub_r5", 4'h5, 16'h0002);
        check_eq("sub_zero", 32'(flags[1]), 32'd0);

        // Dependent back-to-back pair with instr_valid held high.
        @(negedge clk);
        instr_valid = 1'b1;
        instr = 16'h1346;
        check_eq("b2b_ready0", 32'(instr_ready), 32'd1);
        predict(16'h1346);
        @(negedge clk);
        instr = 16'h1661;
        predict(16'h1661);
        cnt = 1;
        while (!instr_ready && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        check_eq("b2b_gap", 32'(cnt), 32'd4);
        @(negedge clk);
        instr_valid = 1'b0;
        cnt = 0;
        while (!done && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        check_eq("b2b_done_lat", 32'(cnt), 32'd2);
        check_reg("b2b_r6", 4'h6, 16'h0017);
        check_reg("b2b_r1", 4'h1, 16'h002E);

        // Host load and accept in the same cycle: the instruction sees the new R2.
        run_instr(16'h1128, 1'b1, 4'h2, 16'h0100);
        check_reg("ldacc_r8", 4'h8, 16'h012E);

        // NOP: retires after one cycle, nothing changes.
        run_instr(16'h0FFF, 1'b0, 4'h0, 16'h0000);
        check_reg("nop_rf", 4'hF, m_regs[15]);

        // HALT: inputs ignored until reset.
        @(negedge clk);
        instr_valid = 1'b1;
        instr = 16'hF000;
        @(negedge clk);
        check_eq("halt_halted", 32'(halted), 32'd1);
        check_eq("halt_ready", 32'(instr_ready), 32'd0);
        instr = 16'h1123;
        load_en = 1'b1; load_addr = 4'h1; load_data = 16'hBEEF;
        repeat (5) @(negedge clk);
        check_eq("halt_stays", 32'(halted), 32'd1);
        instr_valid = 1'b0;
        load_en = 1'b0;
        check_reg("halt_noload", 4'h1, m_regs[1]);
        check_reg("halt_nowb", 4'h3, m_regs[3]);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        check_eq("unhalt_halted", 32'(halted), 32'd0);
        check_eq("unhalt_ready", 32'(instr_ready), 32'd1);
        check_reg("unhalt_r1", 4'h1, 16'h0000);

        // Reset during EXEC drops the write-back and the done pulse.
        host_load(4'h1, 16'h0005);
        host_load(4'h2, 16'h0003);
        @(negedge clk);
        instr_valid = 1'b1;
        instr = 16'h1127;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        check_eq("mid_exec_op", 32'(alu_opcode), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        check_eq("mid_done", 32'(done), 32'd0);
        check_eq("mid_result", 32'(result), 32'd0);
        check_eq("mid_flags", 32'(flags), 32'd0);
        check_eq("mid_rx", 32'(alu_rx_value), 32'd0);
        check_eq("mid_ry", 32'(alu_ry_value), 32'd0);
        check_eq("mid_op", 32'(alu_opcode), 32'd0);
        check_eq("mid_ready", 32'(instr_ready), 32'd1);
        check_reg("mid_r7", 4'h7, 16'h0000);
        repeat (4) @(negedge clk);

        // Recovery: aliasing rx/ry/rd on R0 with carry-out.
        host_load(4'h0, 16'h8001);
        run_instr(16'h1000, 1'b0, 4'h0, 16'h0000);
        check_reg("alias_r0", 4'h0, 16'h0002);
        check_eq("alias_carry", 32'(flags[2]), 32'd1);
        run_instr(16'h6000, 1'b0, 4'h0, 16'h0000);
        repeat (2) @(negedge clk);
        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
        for (int i = 0; i < 16; i++) begin
            check_reg("final_rf", 4'(i), m_regs[i]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
